gray_sobel: RTL

- Streaming 3x3 Sobel edge detector directly downstream of the RGB-to-gray converter.
- Consumes one 8-bit gray pixel per handshake in raster order and emits one 8-bit saturated edge magnitude per input pixel position, in the same raster order and with the same frame size.
- Feeds later thresholding/output stages in the image pipeline.
- Two internal line buffers hold the previous two rows; a small FSM handles fill, run and end-of-frame flush.

---
 rtl/img_pkg.sv | 20 ++
 rtl/gray_line_buffer.sv | 40 ++++
 rtl/gray_sobel.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared types and helpers for the gray-domain image pipeline stages.
package img_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } sobel_state_t;

    localparam int PIX_MAX = 255;

    // Clamp a 12-bit unsigned magnitude to the 8-bit pixel range.
    function automatic pixel_t sat8(input logic [11:0] v);
        return (v > 12'(PIX_MAX)) ? 8'(PIX_MAX) : v[7:0];
    endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// WIDTH-deep 8-bit delay line. dout is the pixel written WIDTH writes ago;
// the slot being read is the slot being overwritten, so a circular pointer
// is enough and the pointer never needs to be aligned to the frame.
module gray_line_buffer
    import img_pkg::*;
#(
    parameter int WIDTH = 640
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   we,
    input  pixel_t din,
    output pixel_t dout
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(WIDTH - 1);

    pixel_t        mem [WIDTH];
    logic [AW-1:0] ptr;

    assign dout = mem[ptr];

    // Storage: contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr] <= din;
        end
    end

    // Circular write/read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (we) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/gray_sobel.sv
// Streaming 3x3 Sobel edge detector on 8-bit gray pixels, raster order.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for in_sof; pixels without in_sof are discarded
// FILL  | storing the first WIDTH+1 pixels, no output yet
// RUN   | one output per accepted pixel (centre lags by WIDTH+1)
// FLUSH | input stalled, emit the trailing WIDTH+1 border zeros
module gray_sobel
    import img_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic [7:0] out_pixel
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    sobel_state_t  state_q, state_d;
    logic [CW-1:0] col_q, pos_col;
    logic [RW-1:0] row_q, pos_row;
    logic [FW-1:0] flush_q;
    logic          rdy_q;

    logic          slot_free, accept, take;
    logic          emit_run, emit_flush, flush_start;

    pixel_t        lb1_out, lb2_out;
    pixel_t        win [3][2];

    logic [9:0]    gx_p, gx_n, gy_p, gy_n;
    logic [10:0]   gx, gy, gx_neg, gy_neg;
    logic [9:0]    ax, ay;
    logic [11:0]   mag;
    logic          interior;
    pixel_t        edge_val;

    // Output slot is free when empty or being drained this cycle.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = rdy_q && slot_free && (state_q != FLUSH);
    assign accept    = in_valid && in_ready;
    // A pixel enters the window/line buffers unless it is discarded in IDLE.
    assign take      = accept && (in_sof || (state_q != IDLE));

    // Raster position of the pixel being accepted; in_sof restarts at (0,0).
    assign pos_col = in_sof ? '0 : col_q;
    assign pos_row = in_sof ? '0 : row_q;

    gray_line_buffer #(.WIDTH(WIDTH)) u_lb1 (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (take),
        .din  (in_pixel),
        .dout (lb1_out)
    );

    gray_line_buffer #(.WIDTH(WIDTH)) u_lb2 (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (take),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Sobel over the two stored window columns plus the incoming column.
    // Rows: 0 = two lines up (lb2), 1 = one line up (lb1), 2 = current line.
    always_comb begin
        gx_p   = {2'b00, lb2_out} + {1'b0, lb1_out, 1'b0} + {2'b00, in_pixel};
        gx_n   = {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
        gy_p   = {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, in_pixel};
        gy_n   = {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, lb2_out};
        gx     = {1'b0, gx_p} - {1'b0, gx_n};
        gy     = {1'b0, gy_p} - {1'b0, gy_n};
        gx_neg = -gx;
        gy_neg = -gy;
        ax     = gx[10] ? gx_neg[9:0] : gx[9:0];
        ay     = gy[10] ? gy_neg[9:0] : gy[9:0];
        mag    = {2'b00, ax} + {2'b00, ay};
        // Centre is (pos_row-1, pos_col-1); it is interior only when the
        // incoming pixel is at col>=2 and row>=2, which also rules out
        // any window that would wrap across a line end.
        interior = (pos_col >= COL_TWO) && (pos_row >= ROW_TWO);
        edge_val = interior ? sat8(mag) : '0;
    end

    // Next-state and per-cycle load strobes.
    always_comb begin
        state_d     = state_q;
        emit_run    = 1'b0;
        emit_flush  = 1'b0;
        flush_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && in_sof) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (in_sof) begin
                        state_d = FILL;
                    end else if (pos_row == ROW_ONE && pos_col == '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (in_sof) begin
                        state_d = FILL;
                    end else begin
                        emit_run = 1'b1;
                        if (pos_row == ROW_LAST && pos_col == COL_LAST) begin
                            state_d     = FLUSH;
                            flush_start = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    emit_flush = 1'b1;
                    if (flush_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus a one-shot enable that holds in_ready low in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    // Raster position counters for the next pixel to arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (take) begin
            if (pos_col == COL_LAST) begin
                col_q <= '0;
                row_q <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_q <= pos_col + 1'b1;
                row_q <= pos_row;
            end
        end
    end

    // Flush down-counter: WIDTH..0 gives the WIDTH+1 trailing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q <= '0;
        end else if (flush_start) begin
            flush_q <= FW'(WIDTH);
        end else if (emit_flush && flush_q != '0) begin
            flush_q <= flush_q - 1'b1;
        end
    end

    // Window columns shift left by one on every stored pixel.
    always_ff @(posedge clk) begin
        if (take) begin
            win[0][0] <= win[0][1];
            win[1][0] <= win[1][1];
            win[2][0] <= win[2][1];
            win[0][1] <= lb2_out;
            win[1][1] <= lb1_out;
            win[2][1] <= in_pixel;
        end
    end

    // Output register; a loaded word holds until out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_pixel <= '0;
        end else if (emit_run) begin
            out_valid <= 1'b1;
            out_sof   <= (pos_row == ROW_ONE) && (pos_col == COL_ONE);
            out_pixel <= edge_val;
        end else if (emit_flush) begin
            out_valid <= 1'b1;
            out_sof   <= 1'b0;
            out_pixel <= '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
